dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Word-addressed data-memory responder: the target end of the CPU data-memory interface (address from ALU output, write data from rt, MemWrite, read data back to the writeback mux).
- Adds a valid/ready request/response handshake and a programmable wait-state counter. Multi-cycle and pipelined CPU variants can then run against realistic memory latency.
- Holds DEPTH 32-bit words internally. Each transaction is a single read or write with a registered response.

Parameters:
- DEPTH, 128, number of 32-bit words; must be a power of two, 4..4096.
- WAIT, 2, wait-state cycles between request acceptance and response; 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  misaligned or out-of-range access.
- busy  out  1  transaction in flight (any state except IDLE).

Behaviour:
- Reset (rst=0, asynchronous):
  - All memory words are cleared to 0.
  - State goes to IDLE; the wait counter is cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - A transaction in progress is aborted: no write is performed and no response is issued.
- States:
  - IDLE: req_ready=1. On req_valid & req_ready, latch we/addr/wdata/be. Go to WAITS if WAIT>0, else to RESP.
  - WAITS: req_ready=0. The counter loads WAIT-1 on entry and decrements each cycle. At 0, go to RESP.
  - RESP: req_ready=0, rsp_valid=1. On rsp_ready, go to IDLE.
- Latency:
  - Request accepted at edge T gives rsp_valid high from cycle T+1+WAIT.
  - With rsp_ready held at 1, back-to-back throughput is one transaction per WAIT+2 cycles.
- Memory access:
  - The access is performed on the edge entering RESP.
  - Reads sample the array on that edge.
  - Writes update the array on that edge.
  - A read in the next transaction sees the new data.
- Errors:
  - rsp_err=1 if latched addr[1:0]!=0 or addr[31:2]>=DEPTH.
  - On error: no write, rsp_rdata=0.
- Response hold: rsp_rdata and rsp_err are registered and stay stable while rsp_valid=1 and rsp_ready=0. They are cleared to 0 when the response is accepted.
- Write responses: rsp_rdata=0, rsp_err as computed.
- req_be=4'b0000 on a write: memory is unchanged and a normal response is still issued.
- Requester rules:
  - req_valid asserted while req_ready=0 is ignored; the requester must hold it.
  - Request fields are don't-care outside the accepting cycle.
  - rsp_ready outside RESP has no effect.

Optional Feature:
- Macro: DMEM_BYTE_EN.
- Defined: req_be masks writes per byte; disabled bytes keep their old value.
- Undefined:
  - req_be is ignored and every non-error write replaces the full word.
  - be=0 writes also replace the full word.
- Reads are identical in both builds.

Test Plan:
- Reset, WAIT=2, write addr 0x10 data 0xDEADBEEF, rsp_ready=1 -> rsp_valid rises 3 cycles after acceptance, err=0, rdata=0. Then read 0x10 -> rdata=0xDEADBEEF, err=0.
- WAIT=0, alternating write/read to 0x0/0x4 with rsp_ready=1 -> one response every 2 cycles, busy high exactly 1 cycle per transaction, read returns prior write.
- Read 0x13 -> err=1, rdata=0. Write 0x200 with DEPTH=128 -> err=1, memory unchanged (verify by reading 0x0 and 0x1FC).
- Read response with rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err are stable and req_ready=0 throughout. Then rsp_ready=1 -> IDLE next cycle.
- DMEM_BYTE_EN defined: write 0x11223344, then write 0xAABBCCDD with be=4'b0101 -> read gives 0x11BB33DD. Undefined -> read gives 0xAABBCCDD.
- Write 0x8 data 0x55, assert rst low during WAITS, release -> read 0x8 returns 0, no stale rsp_valid after reset.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data-memory target with a valid/ready request/response handshake.
// Latency: request accepted in cycle T gives rsp_valid from cycle T+1+WAIT; WAIT+2 cycles per transaction.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready.
//
// Ports: clk/rst (async active-low); req_valid/req_ready/req_we/req_addr/req_wdata/req_be
// form the request channel. rsp_valid/rsp_ready/rsp_rdata/rsp_err form the response channel.
// busy is high while a transaction is in flight.
// Optional build macro DMEM_BYTE_EN: when defined, req_be masks writes per byte.
// When undefined, every non-error write replaces the whole word.
module dmem_responder #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

  typedef enum logic [1:0] {IDLE, WAITS, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic          wr_en;
  logic [31:0]   wr_word;

  assign accept = req_valid && (state_q == IDLE);

  // With WAIT=0 the access edge is the accept edge itself, so the live request
  // fields are used instead of the not-yet-latched copies.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
  assign acc_idx    = acc_addr[AW+1:2];
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign wr_en      = enter_resp && acc_we && !acc_err;

`ifdef DMEM_BYTE_EN
  always_comb begin
    wr_word = mem_q[acc_idx];
    for (int b = 0; b < 4; b++) begin
      if (acc_be[b]) wr_word[8*b +: 8] = acc_wdata[8*b +: 8];
    end
  end
`else
  logic unused_be;
  assign unused_be = ^acc_be;
  assign wr_word   = acc_wdata;
`endif

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[acc_idx] <= wr_word;
    end
  end

  // Next-state and request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = WAIT_LD;
          state_d = (WAIT == 0) ? RESP : WAITS;
        end
      end
      WAITS: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response registers: captured on entry to RESP, cleared on hand-off.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      rdata_d = (acc_we || acc_err) ? 32'd0 : mem_q[acc_idx];
      err_d   = acc_err;
    end else if ((state_q == RESP) && rsp_ready) begin
      rdata_d = 32'd0;
      err_d   = 1'b0;
    end
  end

  // Outputs.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
